// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight destinations past ID, stalls on
// results that are not yet ready, and registers per-source forward selects for EX.
module fwd_hazard_scoreboard #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = 2,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_W-1:0]   id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic [REG_W-1:0]           id_dest,
  input  logic                       id_wb_en,
  input  logic [SEL_W-1:0]           id_rdy,
  input  logic                       flush,
  output logic                       stall,
  output logic                       ex_valid,
  output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
  output logic [15:0]                stall_cnt
);

  logic [DEPTH-1:1]         sb_v;
  logic [REG_W-1:0]         sb_dest [1:DEPTH-1];
  logic [SEL_W-1:0]         sb_rdy  [1:DEPTH-1];

  logic [NUM_SRC-1:0]       match;
  logic [NUM_SRC-1:0]       hazard;
  logic [SEL_W-1:0]         win_k   [NUM_SRC];
  logic [SEL_W-1:0]         win_rdy [NUM_SRC];
  logic [NUM_SRC*SEL_W-1:0] sel_next;
  logic                     issue;
  logic [SEL_W-1:0]         ins_rdy;

  // Scan oldest to youngest so the youngest matching producer is the one kept.
  always_comb begin
    match    = '0;
    hazard   = '0;
    sel_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      win_k[i]   = '0;
      win_rdy[i] = '0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (id_src_used[i] && (id_src[i*REG_W +: REG_W] != '0) && sb_v[k] &&
            (sb_dest[k] == id_src[i*REG_W +: REG_W])) begin
          match[i]   = 1'b1;
          win_k[i]   = SEL_W'(k);
          win_rdy[i] = sb_rdy[k];
        end
      end
      if (FWD_EN) begin
        hazard[i] = match[i] && (win_k[i] < win_rdy[i]);
        sel_next[i*SEL_W +: SEL_W] = match[i] ? win_k[i] : '0;
      end else begin
        hazard[i] = match[i];
      end
    end
  end

  assign stall   = id_valid & ~flush & (|hazard);
  assign issue   = id_valid & ~stall & ~flush;
  assign ins_rdy = (id_rdy == '0) ? SEL_W'(1) : id_rdy;

  // Scoreboard shift plus the EX-stage registers; a non-issuing cycle inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v       <= '0;
      ex_valid   <= 1'b0;
      ex_fwd_sel <= '0;
      stall_cnt  <= '0;
      for (int k = 1; k < DEPTH; k++) begin
        sb_dest[k] <= '0;
        sb_rdy[k]  <= '0;
      end
    end else begin
      for (int k = 2; k < DEPTH; k++) begin
        sb_v[k]    <= sb_v[k-1];
        sb_dest[k] <= sb_dest[k-1];
        sb_rdy[k]  <= sb_rdy[k-1];
      end
      sb_v[1]    <= issue & id_wb_en & (id_dest != '0);
      sb_dest[1] <= id_dest;
      sb_rdy[1]  <= ins_rdy;
      ex_valid   <= issue;
      ex_fwd_sel <= issue ? sel_next : '0;
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
